// File: rtl/fp_mult_pipe.sv
// -----------------------------------------------------------------------------
// fp_mult_pipe
//   IEEE-754 single-precision multiplier with two register ranks.
//   Rank 1 captures the operands, rank 2 holds the rounded product and a
//   zero-or-one-hot exception status. One operation per cycle, no backpressure.
//   Denormal inputs are treated as signed zero and no subnormal is produced.
//
// Parameters
//   RND_DEFAULT  rounding mode used when rnd is 6 or 7
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-low reset, clears both ranks
//   in_valid   in   1   a/b/rnd valid this cycle
//   a, b       in   32  operands, IEEE-754 single
//   rnd        in   3   0 near-even, 1 to-zero, 2 to +inf, 3 to -inf,
//                       4 nearest ties-up, 5 away-from-zero
//   out_valid  out  1   z/status valid
//   z          out  32  product
//   status     out  8   [0]zero [1]inf [2]nan [3]tiny [4]huge [5]inexact,
//                       [7:6] always 0
// -----------------------------------------------------------------------------
module fp_mult_pipe #(
    parameter logic [2:0] RND_DEFAULT = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        out_valid,
    output logic [31:0] z,
    output logic [7:0]  status
);

    // ---- Rank 1: operand capture ----
    logic        vld_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  rnd_q;
    logic [2:0]  rnd_d;

    // Modes 6 and 7 are not defined; fold them onto the default here so the
    // datapath only ever sees modes 0..5.
    assign rnd_d = (rnd[2] && rnd[1]) ? RND_DEFAULT : rnd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            rnd_q <= 3'd0;
        end else begin
            vld_q <= in_valid;
            a_q   <= a;
            b_q   <= b;
            rnd_q <= rnd_d;
        end
    end

    // ---- Combinational multiply / round between the ranks ----
    logic        sa, sb, sz;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic [23:0] mant_sel;
    logic        guard, sticky, inc;
    logic [24:0] mant_rnd;
    logic signed [9:0] exp_pre, exp_post;
    logic        to_inf, away;
    logic [31:0] z_d;
    logic [7:0]  status_d;

    assign sa = a_q[31];
    assign sb = b_q[31];
    assign ea = a_q[30:23];
    assign eb = b_q[30:23];
    assign ma = a_q[22:0];
    assign mb = b_q[22:0];
    assign sz = sa ^ sb;

    // A zero exponent covers both true zero and flushed denormals.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'h0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'h0);
    assign a_nan  = (ea == 8'hFF) && (ma != 23'h0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'h0);

    assign prod = {24'h0, 1'b1, ma} * {24'h0, 1'b1, mb};

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); bit 47 marks [2,4).
        if (prod[47]) begin
            mant_sel = prod[47:24];
            guard    = prod[23];
            sticky   = |prod[22:0];
        end else begin
            mant_sel = prod[46:23];
            guard    = prod[22];
            sticky   = |prod[21:0];
        end
        exp_pre = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
                  + $signed({9'd0, prod[47]});

        case (rnd_q)
            3'd0:    inc = guard & (sticky | mant_sel[0]);
            3'd1:    inc = 1'b0;
            3'd2:    inc = ~sz & (guard | sticky);
            3'd3:    inc = sz & (guard | sticky);
            3'd4:    inc = guard;
            default: inc = guard | sticky;
        endcase

        mant_rnd = {1'b0, mant_sel} + {24'd0, inc};
        // A carry-out leaves mant_rnd[23:0] all zero, i.e. significand 1.0.
        exp_post = exp_pre + $signed({9'd0, mant_rnd[24]});

        // Direction of the saturating results for overflow and underflow.
        to_inf = (rnd_q == 3'd0) || (rnd_q == 3'd4) || (rnd_q == 3'd5) ||
                 (rnd_q == 3'd2 && !sz) || (rnd_q == 3'd3 && sz);
        away   = (rnd_q == 3'd5) ||
                 (rnd_q == 3'd2 && !sz) || (rnd_q == 3'd3 && sz);

        z_d      = 32'h0;
        status_d = 8'h00;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            z_d      = 32'h7FC0_0000;
            status_d = 8'h04;
        end else if (a_inf || b_inf) begin
            z_d      = {sz, 8'hFF, 23'h0};
            status_d = 8'h02;
        end else if (a_zero || b_zero) begin
            z_d      = {sz, 31'h0};
            status_d = 8'h01;
        end else if (exp_pre <= 10'sd0) begin
            z_d      = away ? {sz, 8'h01, 23'h0} : {sz, 31'h0};
            status_d = 8'h08;
        end else if (exp_post >= 10'sd255) begin
            z_d      = to_inf ? {sz, 8'hFF, 23'h0} : {sz, 8'hFE, 23'h7FFFFF};
            status_d = 8'h10;
        end else begin
            z_d      = {sz, exp_post[7:0], mant_rnd[22:0]};
            status_d = {2'b00, guard | sticky, 5'b00000};
        end
    end

    // ---- Rank 2: result registers ----
    logic        out_valid_q;
    logic [31:0] z_q;
    logic [7:0]  status_q;

    // Bubbles drop out_valid but leave the last result on z/status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            z_q         <= 32'h0;
            status_q    <= 8'h00;
        end else begin
            out_valid_q <= vld_q;
            if (vld_q) begin
                z_q      <= z_d;
                status_q <= status_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign status    = status_q;

endmodule
